// File: rtl/alu_hazard_controller_pkg.sv
// Shared types and constants for the ALU hazard controller.
//   REG_ADDR_W    : architectural register index width (8 registers)
//   FWD_*         : operand source select encoding driven to the ALU muxes
//   pipe_entry_t  : producer tracked while it sits in EX
//   prod_entry_t  : producer tracked while it sits in MEM; the load flag is
//                   dropped because a load's data exists once it leaves MEM
package alu_hazard_controller_pkg;

  localparam int REG_ADDR_W = 3;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] dest;
    logic                  is_load;
  } pipe_entry_t;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] dest;
  } prod_entry_t;

endpackage

// File: rtl/alu_hazard_controller_fwd_compare.sv
// Per-operand producer comparison for the hazard controller.
//   src       : source register index read by the ID instruction
//   use_src   : ID instruction actually reads src
//   ex_entry  : producer currently in EX
//   mem_entry : producer currently in MEM
//   sel       : forwarding select (youngest matching producer wins)
//   load_hit  : the EX producer matches and is a load (data not ready yet)
module hazard_fwd_compare
  import alu_hazard_controller_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  pipe_entry_t           ex_entry,
  input  prod_entry_t           mem_entry,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = use_src & ex_entry.valid & ex_entry.wr_en
                   & (ex_entry.dest == src);
  assign mem_match = use_src & mem_entry.valid & mem_entry.wr_en
                   & (mem_entry.dest == src);
  assign load_hit  = ex_match & ex_entry.is_load;

  // A producer in WB needs no select: the register file writes before it is read.
  assign sel = ex_match  ? FWD_EXMEM :
               mem_match ? FWD_MEMWB : FWD_REGFILE;

endmodule

// File: rtl/alu_hazard_controller.sv
// Operand-delivery controller for the 16-bit ALU stage.
//   clk, rst       : clock, asynchronous active-high reset
//   id_*           : instruction presented in the decode stage
//   flush          : taken branch resolved in EX; kill the ID instruction
//   stall          : combinational load-use stall (hold IF/ID, bubble into EX)
//   ex_valid       : instruction now in EX is real
//   ex_fwd_sel1/2  : registered operand source selects for the EX instruction
//   stall_count    : saturating count of stall cycles
// A producer that has reached WB is covered by register-file write-before-read,
// so only the EX and MEM producers are held for comparison.
module alu_hazard_controller #(
  parameter int REG_ADDR_W = alu_hazard_controller_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [1:0]            ex_fwd_sel1,
  output logic [1:0]            ex_fwd_sel2,
  output logic [CNT_W-1:0]      stall_count
);

  import alu_hazard_controller_pkg::*;

  pipe_entry_t ex_q;
  prod_entry_t mem_q;
  pipe_entry_t ex_d;
  logic [1:0]  sel1_c, sel2_c;
  logic [1:0]  sel1_d, sel2_d;
  logic        hit1, hit2;

  hazard_fwd_compare u_cmp1 (
    .src       (id_src1),
    .use_src   (id_use_src1),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .sel       (sel1_c),
    .load_hit  (hit1)
  );

  hazard_fwd_compare u_cmp2 (
    .src       (id_src2),
    .use_src   (id_use_src2),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .sel       (sel2_c),
    .load_hit  (hit2)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if leaves a value unassigned and no latch is inferred.
    stall  = id_valid & ~flush & (hit1 | hit2);
    ex_d   = '0;
    sel1_d = FWD_REGFILE;
    sel2_d = FWD_REGFILE;
    // Flush and stall both send a bubble; flush also masks the stall above.
    if (!flush && !stall) begin
      ex_d   = '{valid: id_valid, wr_en: id_wr_en, dest: id_dest, is_load: id_is_load};
      sel1_d = sel1_c;
      sel2_d = sel2_c;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, making mem_q take the old ex_q rather than ex_d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      ex_fwd_sel1 <= FWD_REGFILE;
      ex_fwd_sel2 <= FWD_REGFILE;
      stall_count <= '0;
    end else begin
      mem_q       <= '{valid: ex_q.valid, wr_en: ex_q.wr_en, dest: ex_q.dest};
      ex_q        <= ex_d;
      ex_fwd_sel1 <= sel1_d;
      ex_fwd_sel2 <= sel2_d;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign ex_valid = ex_q.valid;

endmodule

// File: tb/tb_alu_hazard_controller.sv
// Directed bench for alu_hazard_controller: a vector table walked one
// instruction per cycle, then hand-written reset and saturation sequences.
// A second instance with a 4-bit counter shares all inputs so saturation
// is reachable in a few dozen cycles.
module tb_alu_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_src1, id_src2, id_dest;
  logic       id_use_src1, id_use_src2, id_wr_en, id_is_load, flush;

  logic        stall, ex_valid;
  logic [1:0]  ex_fwd_sel1, ex_fwd_sel2;
  logic [15:0] stall_count;

  logic        stall_s, ex_valid_s;
  logic [1:0]  sel1_s, sel2_s;
  logic [3:0]  count_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_hazard_controller dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wr_en(id_wr_en), .id_dest(id_dest), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2),
    .stall_count(stall_count)
  );

  alu_hazard_controller #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wr_en(id_wr_en), .id_dest(id_dest), .id_is_load(id_is_load),
    .flush(flush), .stall(stall_s), .ex_valid(ex_valid_s),
    .ex_fwd_sel1(sel1_s), .ex_fwd_sel2(sel2_s),
    .stall_count(count_s)
  );

  typedef struct {
    logic       v;
    logic [2:0] s1, s2;
    logic       u1, u2, w;
    logic [2:0] d;
    logic       ld, fl;
    logic       e_stall, e_ev;
    logic [1:0] e_s1, e_s2;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                     input logic u1, input logic u2, input logic w, input logic [2:0] d,
                     input logic ld, input logic fl, input logic es, input logic eev,
                     input logic [1:0] e1, input logic [1:0] e2, input logic [15:0] ec);
    vec_t t;
    t = '{v: v, s1: s1, s2: s2, u1: u1, u2: u2, w: w, d: d, ld: ld, fl: fl,
          e_stall: es, e_ev: eev, e_s1: e1, e_s2: e2, e_cnt: ec};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic w, input logic [2:0] d,
                       input logic ld, input logic fl);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
    id_wr_en = w; id_dest = d; id_is_load = ld; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   v s1 s2 u1 u2 w d ld fl | stall ev s1 s2 cnt
    add(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0); // ADD R1
    add(1, 1, 7, 1, 1, 1, 6, 0, 0,  0, 1, 1, 0, 0); // SUB R6,R1,R7: R1 in EX
    add(1, 3, 1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 2, 0); // R1 now in MEM
    add(1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0); // R1 in WB -> regfile
    add(1, 5, 0, 1, 0, 1, 2, 1, 0,  0, 1, 0, 0, 0); // LOAD R2
    add(1, 2, 4, 1, 1, 1, 3, 0, 0,  1, 0, 0, 0, 1); // ADD R3,R2,R4: load-use
    add(1, 2, 4, 1, 1, 1, 3, 0, 0,  0, 1, 2, 0, 1); // retried: load in MEM
    add(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 1); // ADD R5
    add(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 1); // ADD R5 again
    add(1, 5, 5, 1, 1, 0, 0, 0, 0,  0, 1, 1, 1, 1); // youngest R5 wins
    add(1, 0, 0, 0, 0, 1, 2, 1, 0,  0, 1, 0, 0, 1); // LOAD R2
    add(1, 2, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1); // consumer under flush
    add(1, 2, 0, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1); // next: load in MEM
    add(1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 1); // ADD R0
    add(1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1); // R0 forwards normally
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1); // idle
    add(1, 0, 0, 0, 0, 1, 4, 1, 0,  0, 1, 0, 0, 1); // LOAD R4
    add(1, 4, 4, 0, 1, 1, 6, 0, 0,  1, 0, 0, 0, 2); // src2 hit; src1 unused
    add(1, 4, 4, 0, 1, 1, 6, 0, 0,  0, 1, 0, 2, 2);
    add(1, 0, 0, 0, 0, 1, 7, 1, 0,  0, 1, 0, 0, 2); // LOAD R7
    add(0, 7, 7, 1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 2); // invalid ID never stalls

    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_sel1", 32'(ex_fwd_sel1), 32'd0);
    check("rst_sel2", 32'(ex_fwd_sel2), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].u1, vecs[i].u2,
            vecs[i].w, vecs[i].d, vecs[i].ld, vecs[i].fl);
      #1;
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_ev));
      check($sformatf("v%0d_sel1", i), 32'(ex_fwd_sel1), 32'(vecs[i].e_s1));
      check($sformatf("v%0d_sel2", i), 32'(ex_fwd_sel2), 32'(vecs[i].e_s2));
      check($sformatf("v%0d_count", i), 32'(stall_count), 32'(vecs[i].e_cnt));
    end

    // Reset while a load sits in EX and its consumer is in ID.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0);
    @(negedge clk);
    drive(1, 2, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("async_rst_sel1", 32'(ex_fwd_sel1), 32'd0);
    check("async_rst_sel2", 32'(ex_fwd_sel2), 32'd0);
    check("async_rst_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_ex_valid", 32'(ex_valid), 32'd1);
    check("post_rst_sel1", 32'(ex_fwd_sel1), 32'd0);

    // Back-to-back self-dependent loads: one stall every two cycles.
    @(negedge clk);
    drive(1, 2, 0, 1, 0, 1, 2, 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("sat%0d_issue_stall", i), 32'(stall), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("sat%0d_stall", i), 32'(stall), 32'd1);
      check($sformatf("sat%0d_stall_s", i), 32'(stall_s), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_count_s", i), 32'(count_s), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
    end
    check("sat_main_count", 32'(stall_count), 32'd20);
    check("sat_ex_valid", 32'(ex_valid), 32'd0);
    check("sat_ex_valid_s", 32'(ex_valid_s), 32'd0);
    check("sat_sel1_s", 32'(sel1_s), 32'd0);
    check("sat_sel2_s", 32'(sel2_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_hazard_controller.md
Name: alu_hazard_controller

Overview:
- Sequences operand delivery to the 16-bit ALU stage.
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Issues registered forwarding selects for both ALU operands: register file, EX/MEM result buffer, or MEM/WB result buffer.
- Detects load-use hazards, inserts a one-cycle bubble, honours branch flushes, and keeps a saturating stall counter.

Parameters:
- REG_ADDR_W, 3, register index width (8 architectural registers)
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  decode stage holds a valid instruction
- id_src1  input  REG_ADDR_W  first source register index
- id_src2  input  REG_ADDR_W  second source register index
- id_use_src1  input  1  instruction reads src1
- id_use_src2  input  1  instruction reads src2
- id_wr_en  input  1  instruction writes a register
- id_dest  input  REG_ADDR_W  destination register index
- id_is_load  input  1  instruction is a memory load (result valid only after MEM)
- flush  input  1  branch taken resolved in EX; kill instruction in ID
- stall  output  1  combinational; hold IF/ID, insert bubble into EX
- ex_valid  output  1  registered; instruction now in EX is real (not a bubble)
- ex_fwd_sel1  output  2  registered; operand 1 source: 0 regfile, 1 EX/MEM buffer, 2 MEM/WB buffer
- ex_fwd_sel2  output  2  registered; same encoding for operand 2
- stall_count  output  CNT_W  registered count of stall cycles, saturating

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-high. While rst is high, all tracking entries are invalid and ex_valid=0, ex_fwd_sel1=ex_fwd_sel2=0, stall=0, stall_count=0.
- Tracking entries ex, mem, wb: each holds {valid, wr_en, dest, is_load}.
- Advance every cycle: wb<=mem; mem<=ex; ex<=new entry.
- New entry:
  - If flush: invalid bubble; fwd selects 0.
  - Else if stall: invalid bubble; fwd selects 0.
  - Else: {id_valid, id_wr_en, id_dest, id_is_load}, with computed fwd selects.
  - ex_valid equals the valid bit of the ex entry.
- Match condition, per operand n: use_srcn & entry.valid & entry.wr_en & entry.dest==id_srcn.
- Forwarding, per operand, evaluated on the ID instruction against the current entries:
  - Match in ex -> sel 1.
  - Else match in mem -> sel 2.
  - Else -> sel 0. A producer in wb is covered by register-file write-before-read.
  - The youngest producer (ex) wins when ex and mem both match.
- Load-use stall:
  - stall = id_valid & ~flush & (a match in ex on either operand where ex.is_load=1).
  - Stall lasts exactly one cycle. On the next cycle the load is in mem, so the match resolves to sel 2 and stall drops.
- Flush:
  - Has priority over stall; stall forced 0 in the flush cycle.
  - Entries already in mem and wb are unaffected.
- Register index 0 is not special; it forwards like any other register.
- stall_count increments by 1 on each cycle stall=1 and holds at 2^CNT_W-1.
- Latency: ex_fwd_sel*/ex_valid appear 1 cycle after the instruction is presented at ID with stall=0.
- Reset mid-stream: all in-flight entries are discarded; no forwarding to pre-reset producers after rst falls.

Decomposition:
- Shared package constants: FWD_REGFILE=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2; REG_ADDR_W.
- Shared package typedef: pipe_entry_t {valid, wr_en, dest, is_load}.
- One natural sub-module: hazard_fwd_compare. Combinational, per operand; inputs are the src index, use bit and the ex/mem entries; outputs are the sel and the load-hit flag. Instantiate twice.

Test Plan:
- ADD R1 issued, then SUB using R1 as src1 next cycle -> ex_fwd_sel1=1, stall=0. Third instruction using R1 -> sel 2. Fourth -> sel 0.
- LOAD R2, then ADD R3,R2,R4 immediately -> stall=1 for exactly one cycle; ex_valid=0 bubble; then ex_fwd_sel1=2; stall_count=1.
- ADD R5 then ADD R5 then consumer of R5 -> sel 1 (youngest), not 2.
- LOAD R2 followed by consumer of R2 with flush=1 in that cycle -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
- Assert rst while a LOAD is in ex and a consumer is in ID -> stall=0 and all outputs 0 immediately (asynchronous). After release, a consumer of R2 -> sel 0.
- Force 65535 stall cycles (repeated load-use) plus more -> stall_count saturates at 16'hFFFF.
